dram_responder: RTL and testbench
=================================

Name: dram_responder

Overview:
- Memory-side responder for the GPU's single DRAM slave port; answers word reads and writes from the interconnect.
- Contains a word-addressed storage array, a fixed-latency read pipeline and an in-order response FIFO with consumer backpressure.
- Used as the DRAM endpoint in system simulation and as an on-chip scratch memory on FPGA builds.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width.
- MEM_WORDS, 4096, storage depth in words (power of two).
- READ_LATENCY, 3, cycles from read accept to earliest o_rvalid (>=1).
- QUEUE_DEPTH, 4, max outstanding reads (in pipeline plus FIFO).
- REFRESH_PERIOD, 256, cycles between refresh stalls (used only with the optional feature).
- REFRESH_CYCLES, 8, stall length in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- i_req  in  1  request valid.
- i_we  in  1  1 = write, 0 = read.
- i_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- i_wdata  in  DATA_WIDTH  write data.
- o_ready  out  1  request accepted this cycle when i_req && o_ready.
- o_rvalid  out  1  read response valid.
- o_rdata  out  DATA_WIDTH  read response data.
- o_rerr  out  1  response is for an out-of-range address.
- i_rready  in  1  consumer pops response when o_rvalid && i_rready.
- o_outstanding  out  $clog2(QUEUE_DEPTH+1)  reads in flight plus queued.

Behaviour:
- Reset values: o_rvalid=0, o_rdata=0, o_rerr=0, o_outstanding=0, o_ready=1 (feature off), refresh counter=0.
- Reset clears the pipeline, FIFO and counters. In-flight reads are discarded. Storage contents are not reset.
- Word index = i_addr[ADDR_WIDTH-1:2]. In range iff index < MEM_WORDS.
- Write accept: storage updated at the accepting edge. Produces no response and does not count as outstanding. Out-of-range writes are silently dropped.
- Read accept: storage read at the accepting edge.
  - Returns the value written by any earlier accepted write, including a write accepted in the immediately preceding cycle.
  - Out-of-range read returns data 32'hDEADBEEF with err=1.
- Latency: read accepted in cycle t → entry reaches the FIFO so that o_rvalid is high in cycle t+READ_LATENCY, provided the FIFO is empty; otherwise it is queued behind older entries.
- Responses are strictly in accept order.
- FIFO is first-word-fall-through, depth QUEUE_DEPTH. o_rdata/o_rerr are held stable while o_rvalid && !i_rready.
- Counter: o_outstanding increments on read accept and decrements on pop. Both in one cycle leaves it unchanged.
- o_ready = (o_outstanding < QUEUE_DEPTH), combinational from registered state (minus refresh stall). The FIFO therefore can never overflow.
- Full boundary: with o_outstanding == QUEUE_DEPTH, o_ready=0 even if a pop occurs that same cycle; ready returns the cycle after the pop.
- Empty boundary: o_rvalid=0 with o_rdata holding the last popped value; i_rready while empty has no effect.
- i_req while !o_ready: no state change; requester must hold.

Optional Feature:
- Macro DRAM_RESPONDER_REFRESH_STALL_EN.
- When defined:
  - A free-running counter forces o_ready=0 for REFRESH_CYCLES cycles, starting at count REFRESH_PERIOD-REFRESH_CYCLES, then wraps to 0.
  - The first stall begins in cycle REFRESH_PERIOD-REFRESH_CYCLES after reset release.
  - The read pipeline and FIFO drain normally during a stall.
- When undefined: no counter logic; o_ready depends only on the outstanding count.

Test Plan:
- Write 0x1234_5678 to addr 0x40, then read 0x40 in the next cycle with i_rready=1 → o_rvalid exactly 3 cycles after the read accept, o_rdata=0x12345678, o_rerr=0.
- 4 back-to-back reads of 0x0/0x4/0x8/0xC (preloaded 1,2,3,4) with i_rready=0 → o_ready=0 after the 4th accept, o_outstanding=4. Release i_rready → data 1,2,3,4 in order on consecutive cycles; o_ready returns the cycle after the first pop.
- With 3 outstanding, accept a read and pop in the same cycle → o_outstanding stays 3 and o_ready stays 1.
- Read addr MEM_WORDS*4 → o_rdata=0xDEADBEEF, o_rerr=1. Write to that address then read word 0 → word 0 unchanged.
- Assert rst one cycle after 2 read accepts → o_rvalid never rises for them, o_outstanding=0, o_ready=1. A previously written word retains its value.
- With DRAM_RESPONDER_REFRESH_STALL_EN defined and default parameters → o_ready low in cycles 248..255 after reset, high at 256, low again at 504..511. A read accepted at 247 still returns at 250.

Source files
------------

// File: rtl/dram_responder_if.sv
// Request/response bus between the interconnect and the DRAM responder.
// master: requester/consumer side. slave: memory side.
interface dram_responder_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned QUEUE_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic                  i_req;
    logic                  i_we;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic                  o_ready;
    logic                  o_rvalid;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic                  o_rerr;
    logic                  i_rready;
    logic [CNT_W-1:0]      o_outstanding;

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_rready,
        input  o_ready, o_rvalid, o_rdata, o_rerr, o_outstanding
    );

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_rready,
        output o_ready, o_rvalid, o_rdata, o_rerr, o_outstanding
    );
endinterface

// File: rtl/dram_responder.sv
// Word-addressed memory responder: storage array, fixed-latency read pipeline and
// an in-order first-word-fall-through response FIFO with consumer backpressure.
// Optional periodic refresh stall on o_ready: define DRAM_RESPONDER_REFRESH_STALL_EN.
module dram_responder #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_WORDS      = 4096,
    parameter int unsigned READ_LATENCY   = 3,
    parameter int unsigned QUEUE_DEPTH    = 4,
    parameter int unsigned REFRESH_PERIOD = 256,
    parameter int unsigned REFRESH_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst,
    dram_responder_if.slave bus
);
    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEADBEEF);

    logic [ADDR_WIDTH-3:0] word_idx;
    logic                  in_range;
    logic                  stall;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  pop;
    logic                  push;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  push_err;
    logic                  unused_addr_lsb;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [DATA_WIDTH-1:0] fifo_d_q [QUEUE_DEPTH];
    logic                  fifo_e_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PTR_W-1:0]      wr_ptr_nxt, rd_ptr_nxt;
    logic [CNT_W-1:0]      fifo_cnt_q, out_cnt_q;
    logic [DATA_WIDTH-1:0] last_d_q;
    logic                  last_e_q;

    assign unused_addr_lsb = ^bus.i_addr[1:0];
    assign word_idx = bus.i_addr[ADDR_WIDTH-1:2];
    // Compare at 64 bits so a MEM_WORDS equal to the full index space cannot truncate.
    assign in_range = 64'(word_idx) < 64'(MEM_WORDS);
    assign wr_acc   = bus.i_req && bus.o_ready && bus.i_we;
    assign rd_acc   = bus.i_req && bus.o_ready && !bus.i_we;
    assign pop      = bus.o_rvalid && bus.i_rready;
    assign rd_word  = in_range ? mem[word_idx[IDX_W-1:0]] : ERR_DATA;

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            mem[word_idx[IDX_W-1:0]] <= bus.i_wdata;
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_no_pipe
            assign push      = rd_acc;
            assign push_data = rd_word;
            assign push_err  = !in_range;
        end else begin : g_pipe
            localparam int unsigned STAGES = READ_LATENCY - 1;
            logic                  pipe_v_q [STAGES];
            logic [DATA_WIDTH-1:0] pipe_d_q [STAGES];
            logic                  pipe_e_q [STAGES];

            // Read pipeline: stage i holds a read accepted i+1 cycles ago.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < int'(STAGES); i++) begin
                        pipe_v_q[i] <= 1'b0;
                        pipe_d_q[i] <= '0;
                        pipe_e_q[i] <= 1'b0;
                    end
                end else begin
                    pipe_v_q[0] <= rd_acc;
                    pipe_d_q[0] <= rd_word;
                    pipe_e_q[0] <= !in_range;
                    for (int i = 1; i < int'(STAGES); i++) begin
                        pipe_v_q[i] <= pipe_v_q[i-1];
                        pipe_d_q[i] <= pipe_d_q[i-1];
                        pipe_e_q[i] <= pipe_e_q[i-1];
                    end
                end
            end

            assign push      = pipe_v_q[STAGES-1];
            assign push_data = pipe_d_q[STAGES-1];
            assign push_err  = pipe_e_q[STAGES-1];
        end
    endgenerate

    // Pointer wrap for depths that are not a power of two.
    always_comb begin
        wr_ptr_nxt = (wr_ptr_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        rd_ptr_nxt = (rd_ptr_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    // FIFO payload storage; never overflows since o_ready caps outstanding reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_d_q[wr_ptr_q] <= push_data;
            fifo_e_q[wr_ptr_q] <= push_err;
        end
    end

    // FIFO pointers, occupancy, outstanding count and last-popped response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            out_cnt_q  <= '0;
            last_d_q   <= '0;
            last_e_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_nxt;
            if (pop) begin
                rd_ptr_q <= rd_ptr_nxt;
                last_d_q <= fifo_d_q[rd_ptr_q];
                last_e_q <= fifo_e_q[rd_ptr_q];
            end
            if (push && !pop) fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
            else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
            if (rd_acc && !pop) out_cnt_q <= out_cnt_q + CNT_W'(1);
            else if (!rd_acc && pop) out_cnt_q <= out_cnt_q - CNT_W'(1);
        end
    end

`ifdef DRAM_RESPONDER_REFRESH_STALL_EN
    localparam int unsigned REF_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    logic [REF_W-1:0] ref_cnt_q;

    // Free-running refresh counter; stall occupies the last REFRESH_CYCLES counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt_q <= '0;
        end else if (ref_cnt_q == REF_W'(REFRESH_PERIOD - 1)) begin
            ref_cnt_q <= '0;
        end else begin
            ref_cnt_q <= ref_cnt_q + REF_W'(1);
        end
    end

    assign stall = ref_cnt_q >= REF_W'(REFRESH_PERIOD - REFRESH_CYCLES);
`else
    assign stall = 1'b0;
`endif

    // Outputs: head of FIFO when valid, otherwise hold the last popped response.
    always_comb begin
        bus.o_rvalid      = fifo_cnt_q != '0;
        bus.o_rdata       = bus.o_rvalid ? fifo_d_q[rd_ptr_q] : last_d_q;
        bus.o_rerr        = bus.o_rvalid ? fifo_e_q[rd_ptr_q] : last_e_q;
        bus.o_outstanding = out_cnt_q;
        bus.o_ready       = (out_cnt_q < CNT_W'(QUEUE_DEPTH)) && !stall;
    end
endmodule

// File: tb/tb_dram_responder.sv
// Directed self-checking bench for dram_responder (default parameters).
module tb_dram_responder;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4096;
    localparam int unsigned RL = 3;
    localparam int unsigned QD = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dram_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .QUEUE_DEPTH(QD)) bus ();

    dram_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW), .READ_LATENCY(RL),
        .QUEUE_DEPTH(QD), .REFRESH_PERIOD(256), .REFRESH_CYCLES(8)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.i_req = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Issue one write; returns one cycle later with i_req dropped.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_addr = addr; bus.i_wdata = data;
        step();
        bus.i_req = 1'b0; bus.i_we = 1'b0;
    endtask

    // Issue one read; returns one cycle after the accept and reports cycles until o_rvalid.
    task automatic rd_wait(input logic [31:0] addr, output int lat);
        bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = addr;
        step();
        bus.i_req = 1'b0;
        lat = 1;
        while (!bus.o_rvalid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        if (bus.o_rvalid !== 1'b0) begin
            $display("FAIL rst_rvalid got %b want 0", bus.o_rvalid); errors++;
        end
        checks++;
        if (bus.o_rdata !== 32'h0) begin
            $display("FAIL rst_rdata got %h want 0", bus.o_rdata); errors++;
        end
        checks++;
        if (bus.o_rerr !== 1'b0) begin
            $display("FAIL rst_rerr got %b want 0", bus.o_rerr); errors++;
        end
        checks++;
        if (bus.o_outstanding !== 3'd0) begin
            $display("FAIL rst_outstanding got %0d want 0", bus.o_outstanding); errors++;
        end
        checks++;
        if (bus.o_ready !== 1'b1) begin
            $display("FAIL rst_ready got %b want 1", bus.o_ready); errors++;
        end
        checks++;
        rst = 1'b0;
        step();
        if (bus.o_ready !== 1'b1 || bus.o_rvalid !== 1'b0) begin
            $display("FAIL post_rst ready/rvalid got %b/%b want 1/0", bus.o_ready, bus.o_rvalid);
            errors++;
        end
        checks++;
    endtask

    task automatic test_write_read();
        int lat;
        do_reset();
        bus.i_rready = 1'b1;
        wr(32'h40, 32'h1234_5678);
        rd_wait(32'h40, lat);
        if (lat !== 3) begin
            $display("FAIL wr_rd_latency got %0d want 3", lat); errors++;
        end
        checks++;
        if (bus.o_rdata !== 32'h1234_5678 || bus.o_rerr !== 1'b0) begin
            $display("FAIL wr_rd_data got %h/%b want 12345678/0", bus.o_rdata, bus.o_rerr);
            errors++;
        end
        checks++;
        step();
        if (bus.o_rvalid !== 1'b0 || bus.o_rdata !== 32'h1234_5678
            || bus.o_outstanding !== 3'd0) begin
            $display("FAIL wr_rd_after_pop got v=%b d=%h o=%0d want v=0 d=12345678 o=0",
                     bus.o_rvalid, bus.o_rdata, bus.o_outstanding);
            errors++;
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.i_rready = 1'b0;
        for (int i = 0; i < 4; i++) wr(32'(i * 4), 32'(i + 1));
        for (int i = 0; i < 4; i++) begin
            bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = 32'(i * 4);
            if (bus.o_ready !== 1'b1) begin
                $display("FAIL b2b_ready_before_%0d got %b want 1", i, bus.o_ready); errors++;
            end
            checks++;
            step();
        end
        bus.i_req = 1'b0;
        if (bus.o_ready !== 1'b0 || bus.o_outstanding !== 3'd4) begin
            $display("FAIL b2b_full got ready=%b out=%0d want 0/4", bus.o_ready,
                     bus.o_outstanding);
            errors++;
        end
        checks++;
        repeat (3) step();
        // Pop cycle at full: ready must stay low until the next cycle.
        bus.i_rready = 1'b1;
        if (bus.o_ready !== 1'b0) begin
            $display("FAIL b2b_ready_on_pop got %b want 0", bus.o_ready); errors++;
        end
        checks++;
        for (int k = 1; k <= 4; k++) begin
            if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 32'(k)) begin
                $display("FAIL b2b_data_%0d got v=%b d=%h want v=1 d=%h", k, bus.o_rvalid,
                         bus.o_rdata, 32'(k));
                errors++;
            end
            checks++;
            step();
            if (k == 1) begin
                if (bus.o_ready !== 1'b1 || bus.o_outstanding !== 3'd3) begin
                    $display("FAIL b2b_ready_return got ready=%b out=%0d want 1/3",
                             bus.o_ready, bus.o_outstanding);
                    errors++;
                end
                checks++;
            end
        end
        if (bus.o_rvalid !== 1'b0 || bus.o_rdata !== 32'd4 || bus.o_outstanding !== 3'd0) begin
            $display("FAIL b2b_empty got v=%b d=%h o=%0d want 0/4/0", bus.o_rvalid,
                     bus.o_rdata, bus.o_outstanding);
            errors++;
        end
        checks++;
        step();
        if (bus.o_outstanding !== 3'd0 || bus.o_rdata !== 32'd4) begin
            $display("FAIL b2b_rready_empty got o=%0d d=%h want 0/4", bus.o_outstanding,
                     bus.o_rdata);
            errors++;
        end
        checks++;
        bus.i_rready = 1'b0;
    endtask

    task automatic test_accept_and_pop();
        do_reset();
        bus.i_rready = 1'b0;
        for (int i = 0; i < 4; i++) wr(32'(i * 4), 32'(16 + i));
        for (int i = 0; i < 3; i++) begin
            bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = 32'(i * 4);
            step();
        end
        bus.i_req = 1'b0;
        step();
        step();
        if (bus.o_outstanding !== 3'd3 || bus.o_rdata !== 32'd16) begin
            $display("FAIL ap_setup got o=%0d d=%h want 3/10", bus.o_outstanding, bus.o_rdata);
            errors++;
        end
        checks++;
        bus.i_req = 1'b1; bus.i_addr = 32'hC; bus.i_rready = 1'b1;
        if (bus.o_ready !== 1'b1) begin
            $display("FAIL ap_ready_same got %b want 1", bus.o_ready); errors++;
        end
        checks++;
        step();
        bus.i_req = 1'b0;
        if (bus.o_outstanding !== 3'd3 || bus.o_ready !== 1'b1) begin
            $display("FAIL ap_count got o=%0d ready=%b want 3/1", bus.o_outstanding,
                     bus.o_ready);
            errors++;
        end
        checks++;
        for (int k = 1; k <= 3; k++) begin
            if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 32'(16 + k)) begin
                $display("FAIL ap_order_%0d got v=%b d=%h want 1/%h", k, bus.o_rvalid,
                         bus.o_rdata, 32'(16 + k));
                errors++;
            end
            checks++;
            step();
        end
        if (bus.o_rvalid !== 1'b0 || bus.o_outstanding !== 3'd0) begin
            $display("FAIL ap_drain got v=%b o=%0d want 0/0", bus.o_rvalid, bus.o_outstanding);
            errors++;
        end
        checks++;
        bus.i_rready = 1'b0;
    endtask

    task automatic test_out_of_range();
        int lat;
        do_reset();
        bus.i_rready = 1'b1;
        wr(32'h0, 32'h0000_0ABC);
        rd_wait(32'(MW * 4), lat);
        if (lat !== 3 || bus.o_rdata !== 32'hDEAD_BEEF || bus.o_rerr !== 1'b1) begin
            $display("FAIL oor_read got lat=%0d d=%h e=%b want 3/deadbeef/1", lat,
                     bus.o_rdata, bus.o_rerr);
            errors++;
        end
        checks++;
        step();
        wr(32'(MW * 4), 32'hCAFE_F00D);
        if (bus.o_outstanding !== 3'd0) begin
            $display("FAIL oor_write_no_resp got o=%0d want 0", bus.o_outstanding); errors++;
        end
        checks++;
        rd_wait(32'h0, lat);
        if (bus.o_rdata !== 32'h0000_0ABC || bus.o_rerr !== 1'b0) begin
            $display("FAIL oor_word0 got %h/%b want 00000abc/0", bus.o_rdata, bus.o_rerr);
            errors++;
        end
        checks++;
        step();
        bus.i_rready = 1'b0;
    endtask

    task automatic test_reset_inflight();
        int lat;
        logic seen;
        do_reset();
        bus.i_rready = 1'b1;
        wr(32'h14, 32'hA5A5_A5A5);
        bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = 32'h0;
        step();
        bus.i_addr = 32'h4;
        step();
        bus.i_req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            if (bus.o_rvalid) seen = 1'b1;
            step();
        end
        if (seen !== 1'b0) begin
            $display("FAIL rsti_rvalid got 1 want 0"); errors++;
        end
        checks++;
        if (bus.o_outstanding !== 3'd0 || bus.o_ready !== 1'b1) begin
            $display("FAIL rsti_state got o=%0d ready=%b want 0/1", bus.o_outstanding,
                     bus.o_ready);
            errors++;
        end
        checks++;
        rd_wait(32'h14, lat);
        if (lat !== 3 || bus.o_rdata !== 32'hA5A5_A5A5) begin
            $display("FAIL rsti_retain got lat=%0d d=%h want 3/a5a5a5a5", lat, bus.o_rdata);
            errors++;
        end
        checks++;
        step();
        bus.i_rready = 1'b0;
    endtask

`ifdef DRAM_RESPONDER_REFRESH_STALL_EN
    task automatic test_refresh();
        logic exp_rdy;
        do_reset();
        bus.i_rready = 1'b0;
        for (int c = 0; c <= 515; c++) begin
            exp_rdy = (c % 256) < 248;
            if (bus.o_ready !== exp_rdy) begin
                $display("FAIL ref_ready_c%0d got %b want %b", c, bus.o_ready, exp_rdy);
                errors++;
            end
            checks++;
            if (c == 10) begin
                bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_addr = 32'h80;
                bus.i_wdata = 32'h0BAD_F00D;
            end
            if (c == 11) begin
                bus.i_req = 1'b0; bus.i_we = 1'b0;
            end
            if (c == 247) begin
                bus.i_req = 1'b1; bus.i_addr = 32'h80; bus.i_rready = 1'b1;
            end
            if (c == 248) bus.i_req = 1'b0;
            if (c == 249) begin
                if (bus.o_rvalid !== 1'b0) begin
                    $display("FAIL ref_early got %b want 0", bus.o_rvalid); errors++;
                end
                checks++;
            end
            if (c == 250) begin
                if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 32'h0BAD_F00D) begin
                    $display("FAIL ref_read got v=%b d=%h want 1/0badf00d", bus.o_rvalid,
                             bus.o_rdata);
                    errors++;
                end
                checks++;
            end
            step();
        end
        bus.i_rready = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
        bus.i_rready = 1'b0;
        test_reset();
`ifdef DRAM_RESPONDER_REFRESH_STALL_EN
        test_refresh();
`endif
        test_write_read();
        test_back_to_back();
        test_accept_and_pop();
        test_out_of_range();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
